// File: rtl/mult_seq_ctrl_if.sv
// Operand/product handshake bundle for the sequential shift-add multiplier.
// The requester/consumer side uses the master modport, the controller the slave.
interface mult_seq_ctrl_if #(
    parameter int D_SIZE = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [D_SIZE-1:0]     a_in;
    logic [D_SIZE-1:0]     b_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*D_SIZE-1:0]   p_out;

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, p_out
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, p_out
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequencing controller for an iterative shift-add multiplier: accepts one
// operand pair, runs D_SIZE add/shift iterations and holds the product until
// it is consumed. All handshake outputs are decoded from state only.
module mult_seq_ctrl #(
    parameter int D_SIZE = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             abort_in,
    mult_seq_ctrl_if.slave   bus,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    localparam int IW = $clog2(D_SIZE);
    localparam logic [IW-1:0] LAST_ITER = IW'(D_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [D_SIZE-1:0]   a_sh;
    logic [2*D_SIZE-1:0] b_sh;
    logic [2*D_SIZE-1:0] acc;
    logic [2*D_SIZE-1:0] acc_next;
    logic [2*D_SIZE-1:0] p_reg;
    logic [IW-1:0]       iter;

    // Partial-product accumulation for the current iteration
    always_comb begin
        acc_next = acc;
        if (a_sh[0]) begin
            acc_next = acc + b_sh;
        end
    end

    // State register
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and state-decoded handshake outputs
    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (!abort_in && bus.in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (abort_in) begin
                    state_next = IDLE;
                end else if (iter == LAST_ITER) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                if (abort_in || bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand, accumulator, product and count registers; abort freezes them
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            a_sh     <= '0;
            b_sh     <= '0;
            acc      <= '0;
            iter     <= '0;
            p_reg    <= '0;
            op_count <= '0;
        end else if (!abort_in) begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh <= bus.a_in;
                        b_sh <= {{D_SIZE{1'b0}}, bus.b_in};
                        acc  <= '0;
                        iter <= '0;
                    end
                end
                RUN: begin
                    acc  <= acc_next;
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh << 1;
                    iter <= iter + 1'b1;
                    if (iter == LAST_ITER) begin
                        p_reg <= acc_next;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        op_count <= op_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.p_out = p_reg;
endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
Sequencing controller for the iterative shift-add multiplier datapath. It accepts one operand pair through a valid/ready handshake and runs exactly D_SIZE shift-add iterations, one per clock. It then presents the full 2*D_SIZE-bit product through a valid/ready output handshake. It sits between any requester and the multiplier, owns all operand, accumulator and count registers, and guarantees the datapath holds only one operation at a time.

Parameters:
D_SIZE, 8, operand width in bits; must be >= 2.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk_in  input  1  clock; all state changes on the rising edge.
rst_n_in  input  1  synchronous, active-low reset.
abort_in  input  1  synchronous flush of any in-flight operation.
in_valid  input  1  requester has an operand pair on a_in/b_in.
in_ready  output  1  controller can accept an operand pair.
a_in  input  D_SIZE  multiplier operand, unsigned.
b_in  input  D_SIZE  multiplicand operand, unsigned.
out_valid  output  1  p_out holds a finished product.
out_ready  input  1  consumer accepts the product.
p_out  output  2*D_SIZE  unsigned product a_in*b_in.
busy  output  1  high in RUN or DONE.
op_count  output  CNT_W  number of products consumed; wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst_n_in is synchronous and active-low.
- Reset (rst_n_in=0 at an edge):
  - state becomes IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - p_out=0, op_count=0.
  - Internal registers cleared: a_sh, b_sh, acc, iter count.
  - Reset overrides abort_in and all handshakes, including mid-RUN and in DONE.
- States: IDLE, RUN, DONE. All outputs are registered or decoded from state only; there is no combinational in->out path.
- IDLE:
  - in_ready=1.
  - Accept when in_valid=1 at an edge. Then a_sh<=a_in, b_sh<={D_SIZE zeros, b_in} (2*D_SIZE wide), acc<=0, iter<=0, next state RUN.
  - Without in_valid, stay in IDLE.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each edge: if a_sh[0]=1 then acc<=acc+b_sh, else acc is unchanged.
  - Each edge also: a_sh<=a_sh>>1 (logical), b_sh<=b_sh<<1, iter<=iter+1.
  - acc is 2*D_SIZE wide, so the addition never overflows and no carry is dropped.
  - On the edge where iter==D_SIZE-1, the final iteration is applied, p_out<=final acc value, next state DONE.
  - No early termination: the iteration count is fixed even when a_sh becomes 0.
- Latency: out_valid rises exactly D_SIZE cycles after the accept edge.
- DONE:
  - out_valid=1. p_out is held stable until consumed.
  - When out_ready=1 at an edge: op_count<=op_count+1, next state IDLE, out_valid=0 after that edge.
  - in_ready stays 0 in DONE, so there is no same-cycle accept. Peak throughput is one product per D_SIZE+2 cycles.
  - out_ready held low keeps DONE indefinitely (backpressure). p_out and out_valid must not change while waiting.
- abort_in=1 at an edge (with rst_n_in=1):
  - From RUN or DONE: next state IDLE, out_valid=0. p_out keeps its old value. op_count does not increment, even if out_ready=1 on the same edge.
  - In IDLE: an abort blocks acceptance that cycle, even with in_valid=1.
- p_out is don't-care whenever out_valid=0. The bench must only check it when out_valid=1.
- Edge cases:
  - Operands of 0 or all-ones are handled normally. For D_SIZE=8, 255*255 = 65025.
  - op_count wraps from 2^CNT_W-1 to 0.

Test Plan:
- Basic: D_SIZE=8, reset, then a_in=13, b_in=11, in_valid for one cycle -> in_ready drops next cycle; out_valid rises exactly 8 cycles after accept; p_out=143; out_ready=1 -> op_count=1, in_ready=1.
- Extremes: 255*255 -> p_out=65025 (0xFE01); 0*200 -> p_out=0 after the full 8 cycles; 1*255 -> 255; 128*2 -> 256.
- Backpressure and busy-ignore: product 7*9 with out_ready=0 for 20 cycles -> out_valid held, p_out=63 stable, op_count=0; in_valid with a_in=3, b_in=3 during RUN/DONE ignored; out_ready=1 -> op_count=1, then next accept yields 9.
- Abort: accept 100*100, assert abort_in on the 4th RUN cycle -> IDLE next cycle, out_valid never asserted, op_count unchanged; following 5*6 -> p_out=30.
- Reset mid-op: accept 200*3, pull rst_n_in low for one edge during RUN -> all outputs at reset values; later 4*4 -> 16, op_count=1.
- Random soak: 1000 random operand pairs with random out_ready stalls -> every p_out equals the reference product, latency always 8, op_count=1000 mod 2^16.
